// File: rtl/ser16_xfer_ctrl.sv
// rtl/ser16_xfer_ctrl.sv - frame sequencer driving a 16-bit load/shift-right serial register
module ser16_xfer_ctrl #(
    parameter int DIV      = 4,
    parameter int NBITS    = 16,
    parameter int CS_SETUP = 2
) (
    input  logic C,
    input  logic CLR,
    input  logic START,
    input  logic ABORT,
    output logic SR_L,
    output logic SR_CE,
    output logic SCK,
    output logic CS_N,
    output logic BUSY,
    output logic DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    // one counter serves both the CS guard intervals and the SCK period
    localparam int CMAX = (2 * DIV > CS_SETUP) ? 2 * DIV : CS_SETUP;
    localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] PER_LAST = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] HI_FIRST = CW'(DIV);
    localparam logic [CW-1:0] SET_LAST = CW'(CS_SETUP - 1);
    localparam logic [4:0]    BIT_LAST = 5'(NBITS - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [4:0]    bitcnt;

    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            SR_L   <= 1'b0;
            SR_CE  <= 1'b0;
            SCK    <= 1'b0;
            CS_N   <= 1'b1;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            SR_L  <= 1'b0;
            SR_CE <= 1'b0;
            DONE  <= 1'b0;
            if (ABORT && state != S_IDLE) begin
                state  <= S_IDLE;
                cnt    <= '0;
                bitcnt <= '0;
                SCK    <= 1'b0;
                CS_N   <= 1'b1;
                BUSY   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (START && !ABORT) begin
                            state  <= S_LOAD;
                            cnt    <= '0;
                            bitcnt <= '0;
                            SR_L   <= 1'b1;
                            CS_N   <= 1'b0;
                            BUSY   <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        state <= S_SETUP;
                        cnt   <= '0;
                    end
                    S_SETUP: begin
                        if (cnt == SET_LAST) begin
                            state <= S_SHIFT;
                            cnt   <= '0;
                            SCK   <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_SHIFT: begin
                        // the cycle just ending carried SR_CE; start the next bit or leave
                        if (cnt == PER_LAST) begin
                            cnt    <= '0;
                            SCK    <= 1'b0;
                            bitcnt <= bitcnt + 5'd1;
                            if (bitcnt == BIT_LAST) begin
                                state <= S_HOLD;
                            end
                        end else begin
                            cnt   <= cnt_inc;
                            SCK   <= (cnt_inc >= HI_FIRST);
                            SR_CE <= (cnt_inc == PER_LAST);
                        end
                    end
                    S_HOLD: begin
                        if (cnt == SET_LAST) begin
                            state <= S_DONE;
                            cnt   <= '0;
                            CS_N  <= 1'b1;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        SCK   <= 1'b0;
                        CS_N  <= 1'b1;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser16_xfer_ctrl.sv
// tb/tb_ser16_xfer_ctrl.sv - randomized self-checking bench for ser16_xfer_ctrl
module tb_ser16_xfer_ctrl;

    logic C = 1'b0;
    logic CLR = 1'b0;
    logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic sr_l0, sr_ce0, sck0, cs_n0, busy0, done0;
    logic sr_l1, sr_ce1, sck1, cs_n1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] IDLE_VEC = 6'b000100;

    always #5 C = ~C;

    ser16_xfer_ctrl u_dut (
        .C(C), .CLR(CLR), .START(start0), .ABORT(abort0),
        .SR_L(sr_l0), .SR_CE(sr_ce0), .SCK(sck0), .CS_N(cs_n0), .BUSY(busy0), .DONE(done0)
    );

    ser16_xfer_ctrl #(.DIV(1), .NBITS(1), .CS_SETUP(1)) u_dut_min (
        .C(C), .CLR(CLR), .START(start1), .ABORT(abort1),
        .SR_L(sr_l1), .SR_CE(sr_ce1), .SCK(sck1), .CS_N(cs_n1), .BUSY(busy1), .DONE(done1)
    );

    // shift register and slave attached to the default instance
    logic [15:0] d_word = '0, reply_word = '0, q = '0, rx = '0;
    int          ce_seen = 0;
    logic        sck_d = 1'b0;

    always @(posedge C) begin
        if (sr_l0) begin
            q       <= d_word;
            ce_seen <= 0;
        end else if (sr_ce0) begin
            q       <= {reply_word[ce_seen[3:0]], q[15:1]};
            ce_seen <= ce_seen + 1;
        end
    end

    always @(negedge C) begin
        sck_d <= sck0;
        if (sck0 && !sck_d) rx <= {q[0], rx[15:1]};
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // expected {SR_L,SR_CE,SCK,CS_N,BUSY,DONE} at cycle offset 'off' after the START edge
    function automatic logic [5:0] model(input int off, input int div, input int nb, input int cs);
        int done_off, p, ph;
        logic [5:0] v;
        done_off = 2 + 2 * cs + 2 * div * nb;
        if (off < 1 || off > done_off) return IDLE_VEC;
        if (off == done_off) return 6'b000101;
        v = 6'b000010;
        v[5] = (off == 1);
        p = off - (2 + cs);
        if (p >= 0 && p < 2 * div * nb) begin
            ph   = p % (2 * div);
            v[3] = (ph >= div);
            v[4] = (ph == 2 * div - 1);
        end
        return v;
    endfunction

    function automatic logic [5:0] obs(input bit sel);
        return sel ? {sr_l1, sr_ce1, sck1, cs_n1, busy1, done1}
                   : {sr_l0, sr_ce0, sck0, cs_n0, busy0, done0};
    endfunction

    task automatic idle_cycles(input int n, input bit rand_abort);
        for (int i = 0; i < n; i++) begin
            abort0 = rand_abort ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge C);
            check("idle0", 32'(obs(0)), 32'(IDLE_VEC));
            check("idle1", 32'(obs(1)), 32'(IDLE_VEC));
        end
        abort0 = 1'b0;
    endtask

    // entered at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic run_frame(input bit sel, input bit spam, input int abort_k, input int clr_at,
                             input logic [15:0] d, input logic [15:0] rep);
        int div, nb, cs, done_off, ces;
        logic [5:0] e;
        div = sel ? 1 : 4;
        nb  = sel ? 1 : 16;
        cs  = sel ? 1 : 2;
        done_off = 2 + 2 * cs + 2 * div * nb;
        d_word = d;
        reply_word = rep;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge C);
        if (!spam) begin start0 = 1'b0; start1 = 1'b0; end
        ces = 0;
        for (int off = 1; off <= done_off + 1; off++) begin
            e = model(off, div, nb, cs);
            check("outs", 32'(obs(sel)), 32'(e));
            if (obs(sel)[4]) ces++;
            if (off == done_off && !sel) begin
                check("rdata", 32'(q), 32'(rep));
                check("txdata", 32'(rx), 32'(d));
            end
            if (off == clr_at) begin
                #2 CLR = 1'b1;
                #1 check("clr_async", 32'(obs(sel)), 32'(IDLE_VEC));
                start0 = 1'b0; start1 = 1'b0;
                @(negedge C);
                check("clr_hold", 32'(obs(sel)), 32'(IDLE_VEC));
                CLR = 1'b0;
                return;
            end
            if (abort_k > 0 && e[4] && ces == abort_k) begin
                if (sel) abort1 = 1'b1; else abort0 = 1'b1;
                @(negedge C);
                abort0 = 1'b0; abort1 = 1'b0;
                check("abort_outs", 32'(obs(sel)), 32'(IDLE_VEC));
                for (int i = 0; i < 4; i++) begin
                    @(negedge C);
                    check("abort_idle", 32'(obs(sel)), 32'(IDLE_VEC));
                end
                if (!sel) check("abort_ce", 32'(ce_seen), 32'(abort_k));
                return;
            end
            if (off <= done_off) @(negedge C);
        end
        check("ce_count", 32'(ces), 32'(nb));
    endtask

    initial begin
        #2 CLR = 1'b1;
        #1 check("reset0", 32'(obs(0)), 32'(IDLE_VEC));
        check("reset1", 32'(obs(1)), 32'(IDLE_VEC));
        @(negedge C);
        CLR = 1'b0;
        idle_cycles(50, 1'b0);

        run_frame(0, 0, 0, 0, 16'hA5C3, 16'h1234);
        run_frame(1, 0, 0, 0, 16'h0, 16'h0);

        run_frame(0, 0, 7, 0, 16'h5A5A, 16'hFFFF);
        run_frame(0, 0, 0, 0, 16'h0F0F, 16'hC001);

        // ABORT and START together in IDLE: nothing starts
        start0 = 1'b1; abort0 = 1'b1;
        @(negedge C);
        start0 = 1'b0; abort0 = 1'b0;
        check("abort_start", 32'(obs(0)), 32'(IDLE_VEC));
        idle_cycles(2, 1'b0);

        start0 = 1'b1;
        run_frame(0, 1, 0, 0, 16'h1357, 16'h2468);
        run_frame(0, 1, 0, 0, 16'hFFFF, 16'h0000);
        run_frame(0, 0, 0, 0, 16'h8001, 16'h7FFE);

        run_frame(0, 0, 0, 8, 16'hDEAD, 16'hBEEF);
        run_frame(0, 0, 0, 0, 16'hA5C3, 16'h1234);

        for (int f = 0; f < 8; f++) begin
            bit sel;
            int k;
            sel = (f % 4 == 3);
            k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, sel ? 1 : 16)) : 0;
            run_frame(sel, 0, k, 0, 16'($urandom), 16'($urandom));
            idle_cycles(int'($urandom_range(0, 3)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
